inc_sequencer: RTL and testbench

Registered address/index sequencer that produces a stream of consecutive `width`-bit values from a captured `BASE` up to a captured `LIMIT`. Values are delivered over a valid/ready handshake. It sits directly upstream of the prefix incrementer `IncC` and instantiates it as its next-value datapath. It feeds `IncC` the current count as `A` and the handshake-fire signal as `CI`, and consumes `Z`/`CO` as next count and wrap indication. Typical use is as an index generator for memory walkers and loop counters in arithmetic test harnesses.

---
 rtl/inc_sequencer.sv | 142 ++++++++++++++
 tb/tb_inc_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inc_sequencer.sv
// Registered BASE..LIMIT value sequencer with valid/ready output, built on the
// IncC prefix incrementer (package lau_pkg and IncC are carried in this file).

package lau_pkg;
  typedef enum logic [1:0] {SLOW, MEDIUM, FAST} speed_t;
endpackage

// Prefix incrementer: Z = A + CI, CO = carry out. The prefix AND chain over
// {A, CI} is shaped by speed: Sklansky (FAST), Brent-Kung (MEDIUM), serial (SLOW).
module IncC #(
  parameter int             width = 8,
  parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
  input  logic [width-1:0] A,
  input  logic             CI,
  output logic [width-1:0] Z,
  output logic             CO
);

  localparam int N = width + 1;
  localparam int L = $clog2(N);

  always_comb begin : prefix
    logic [N-1:0] p;
    p = {A, CI};
    if (speed == lau_pkg::SLOW) begin
      for (int unsigned i = 1; i < N; i++)
        p[i] = p[i] & p[i-1];
    end else if (speed == lau_pkg::MEDIUM) begin
      // Up-sweep builds power-of-two spans, down-sweep fills the gaps in place.
      for (int unsigned l = 0; l < L; l++)
        for (int unsigned i = 0; i < N; i++)
          if ((i + 1) % (2 << l) == 0)
            p[i] = p[i] & p[i - (1 << l)];
      for (int unsigned k = 0; k + 1 < L; k++)
        for (int unsigned i = 0; i < N; i++)
          if (((i + 1) % (2 << (L - 2 - k)) == (1 << (L - 2 - k))) &&
              (i >= (2 << (L - 2 - k))))
            p[i] = p[i] & p[i - (1 << (L - 2 - k))];
    end else begin
      for (int unsigned l = 0; l < L; l++)
        for (int unsigned i = 0; i < N; i++)
          if (((i >> l) & 1) == 1)
            p[i] = p[i] & p[((i >> l) << l) - 1];
    end
    Z  = A ^ p[N-2:0];
    CO = p[N-1];
  end

endmodule

module inc_sequencer #(
  parameter int             width = 8,
  parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [width-1:0] BASE,
  input  logic [width-1:0] LIMIT,
  input  logic             WRAP,
  output logic             VALID,
  input  logic             READY,
  output logic [width-1:0] Z,
  output logic             LAST,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [width-1:0] cnt;
  logic [width-1:0] lim;
  logic             wrap_q;
  logic             ovf_q;
  logic             done_q;
  logic [width-1:0] nxt;
  logic             co;
  logic             run;
  logic             fire;
  logic             at_lim;

  assign run    = (state == RUN);
  assign at_lim = (cnt == lim);
  assign fire   = run & READY;

  IncC #(.width(width), .speed(speed)) u_inc (
    .A  (cnt),
    .CI (fire),
    .Z  (nxt),
    .CO (co)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      lim    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            cnt    <= BASE;
            lim    <= LIMIT;
            wrap_q <= WRAP;
            ovf_q  <= 1'b0;
            state  <= RUN;
          end
        end
        default: begin
          if (fire) begin
            if (at_lim) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else if (co && !wrap_q) begin
              // cnt keeps the all-ones value that overflowed
              ovf_q <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= nxt;
            end
          end
        end
      endcase
    end
  end

  assign VALID = run;
  assign BUSY  = run;
  assign Z     = cnt;
  assign LAST  = run & at_lim;
  assign DONE  = done_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_inc_sequencer.sv
// Scoreboard bench for inc_sequencer across all speed settings at widths 8 and 5.
module tb_inc_sequencer;

  localparam int NCFG = 6;

  logic            clk;
  int              compared   = 0;
  int              mismatched = 0;
  logic [NCFG-1:0] all_fin;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar k = 0; k < NCFG; k++) begin : g
    localparam int              W  = (k < 3) ? 8 : 5;
    localparam lau_pkg::speed_t SP = lau_pkg::speed_t'(k % 3);
    localparam logic [W-1:0]    M  = '1;

    logic         rst, start, wrap, ready;
    logic [W-1:0] base, limit, z;
    logic         valid, last, busy, done, ovf;
    logic         fin;
    logic [W:0]   exp_q[$];

    assign all_fin[k] = fin;

    inc_sequencer #(.width(W), .speed(SP)) dut (
      .CLK   (clk),
      .RST   (rst),
      .START (start),
      .BASE  (base),
      .LIMIT (limit),
      .WRAP  (wrap),
      .VALID (valid),
      .READY (ready),
      .Z     (z),
      .LAST  (last),
      .BUSY  (busy),
      .DONE  (done),
      .OVF   (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      compared++;
      if (act !== want) begin
        mismatched++;
        $display("FAIL cfg%0d %s: got %0h want %0h", k, nm, act, want);
      end
    endtask

    // Reference: walk the value sequence with plain integer arithmetic.
    task automatic model(input logic [W-1:0] b, input logic [W-1:0] l, input logic w,
                         output logic eo, output logic ed);
      int unsigned v;
      int unsigned mx;
      v  = b;
      mx = (1 << W) - 1;
      eo = 1'b0;
      ed = 1'b0;
      for (int n = 0; n <= (1 << W) + 1; n++) begin
        exp_q.push_back({1'(v == l), W'(v)});
        if (v == l) begin
          ed = 1'b1;
          break;
        end
        if (v == mx) begin
          if (!w) begin
            eo = 1'b1;
            break;
          end
          v = 0;
        end else begin
          v++;
        end
      end
    endtask

    initial begin : monitor
      logic [W:0]   e;
      logic         hold_p;
      logic [W-1:0] held;
      hold_p = 1'b0;
      held   = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          hold_p = 1'b0;
        end else begin
          if (hold_p) begin
            chk("stall_z", z, held);
            chk("stall_valid", valid, 1);
            hold_p = 1'b0;
          end
          if (valid && ready) begin
            if (exp_q.size() == 0) begin
              compared++;
              mismatched++;
              $display("FAIL cfg%0d xfer: got z=%0h want no transfer", k, z);
            end else begin
              e = exp_q.pop_front();
              chk("xfer_z", z, e[W-1:0]);
              chk("xfer_last", last, e[W]);
            end
          end else if (valid) begin
            hold_p = 1'b1;
            held   = z;
          end
        end
      end
    end

    task automatic idle(input int c);
      for (int i = 0; i < c; i++) begin
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_valid", valid, 0);
      end
    endtask

    // rmode: 0 = READY held high, 1 = random READY plus ignored START pulses,
    // 2 = READY pattern 1,0,0,1,1,...
    task automatic run_seq(input logic [W-1:0] b, input logic [W-1:0] l, input logic w,
                           input int rmode);
      logic eo, ed;
      start = 1'b1;
      base  = b;
      limit = l;
      wrap  = w;
      model(b, l, w, eo, ed);
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_valid", valid, 1);
      chk("start_z", z, b);
      chk("start_busy", busy, 1);
      chk("done_pulse", done, 0);
      chk("ovf_clear", ovf, 0);
      for (int n = 0; n < (4 << W) + 40; n++) begin
        case (rmode)
          0:       ready = 1'b1;
          1:       ready = ($urandom_range(0, 3) != 0);
          default: ready = !(n == 1 || n == 2);
        endcase
        if (rmode == 1 && $urandom_range(0, 7) == 0) begin
          start = 1'b1;
          base  = W'($urandom);
          limit = W'($urandom);
          wrap  = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (!busy) break;
      end
      chk("end_busy", busy, 0);
      chk("end_done", done, ed);
      chk("end_ovf", ovf, eo);
      chk("end_valid", valid, 0);
      chk("end_last", last, 0);
      chk("end_drain", exp_q.size(), 0);
      if (ed) chk("end_z", z, l);
      exp_q.delete();
    endtask

    task automatic reset_mid();
      logic eo, ed;
      start = 1'b1;
      base  = W'(3);
      limit = W'(9);
      wrap  = 1'b0;
      ready = 1'b1;
      model(W'(3), W'(9), 1'b0, eo, ed);
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 10 && z != W'(5); n++) begin
        @(posedge clk); #1;
      end
      chk("rst_reach5", z, 5);
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_z", z, 0);
      chk("rst_last", last, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        chk("rst_novalid", valid, 0);
        chk("rst_nobusy", busy, 0);
      end
    endtask

    initial begin : stim
      logic [W-1:0] b, l;
      fin   = 1'b0;
      rst   = 1'b0;
      start = 1'b0;
      base  = '0;
      limit = '0;
      wrap  = 1'b0;
      ready = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("reset_valid", valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_last", last, 0);
      chk("reset_z", z, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);
      run_seq(W'(3), W'(6), 1'b0, 0);
      idle(1);
      run_seq(W'(10), W'(12), 1'b0, 2);
      idle(1);
      run_seq(M - 1'b1, W'(1), 1'b1, 0);
      idle(1);
      run_seq(M - 1'b1, W'(1), 1'b0, 0);
      idle(2);
      run_seq(W'(8'h55), W'(8'h55), 1'b0, 0);
      run_seq(W'(8'h20), W'(8'h23), 1'b0, 1);
      idle(1);
      reset_mid();
      idle(1);
      repeat (25) begin
        b = W'($urandom);
        l = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'(b + $urandom_range(0, 6));
        run_seq(b, l, 1'($urandom_range(0, 1)), 1);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      fin = 1'b1;
    end
  end

  initial begin : summary
    for (int c = 0; c < 60000; c++) begin
      @(posedge clk);
      if (&all_fin) break;
    end
    compared++;
    if (!(&all_fin)) begin
      mismatched++;
      $display("FAIL global_timeout: finished=%b want all ones", all_fin);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
